teclado_controlador: RTL and testbench

Sequencing controller for the 4-key membrane keypad encoder. It consumes the encoder's `index_out`/`hab_out` pair, which is combinational and bounces, and synchronises it to `clk`. It debounces press and release, and emits exactly one key event per physical press into a 4-entry FIFO drained through a valid/ready handshake. It sits between the keypad encoder and any consumer, for example a menu FSM or a display driver.

---
 rtl/teclado_controlador.sv | 166 ++++++++++++++++
 tb/tb_teclado_controlador.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/teclado_controlador.sv
// teclado_controlador
//   Sequencing controller for a 4-key membrane keypad encoder. Synchronises the
//   bouncing {hab, index} pair, debounces press and release, and queues exactly
//   one key event per physical press into a 4-entry FIFO read via valid/ready.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : synchronous active-low reset
//   index_in   : encoder key index, meaningful only when hab_in = 0
//   hab_in     : encoder "no valid key" flag (1 = none or several keys)
//   key_data   : key index at the FIFO head
//   key_valid  : FIFO non-empty
//   key_ready  : consumer pops the head entry
//   key_count  : FIFO occupancy, 0..4
//   pressed    : debounced "key held" level
//   overflow   : sticky, an event was dropped on a full FIFO
module teclado_controlador #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] index_in,
    input  logic       hab_in,
    output logic [1:0] key_data,
    output logic       key_valid,
    input  logic       key_ready,
    output logic [2:0] key_count,
    output logic       pressed,
    output logic       overflow
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StDebPress, StHeld, StDebRel} state_e;

    // Synchroniser, {hab, idx}. Resets to "no key" so a key held through reset
    // is seen as a fresh press rather than a glitch.
    logic [2:0] cond_in;
    logic [2:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic       hab_s;
    logic [1:0] idx_s;

    // Index is masked before the first flop so X/Z never gets captured.
    assign cond_in = hab_in ? 3'b100 : {1'b0, index_in};
    assign sync1_d = cond_in;
    assign sync2_d = sync1_q;
    assign hab_s   = sync2_q[2];
    assign idx_s   = sync2_q[1:0];

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      cand_q, cand_d;
    logic            pressed_q, pressed_d;
    logic            push;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        push    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!hab_s) begin
                    cand_d  = idx_s;
                    cnt_d   = '0;
                    state_d = StDebPress;
                end
            end
            StDebPress: begin
                if (hab_s || (idx_s != cand_q)) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else if (cnt_q == CntLast) begin
                    push    = 1'b1;
                    cnt_d   = '0;
                    state_d = StHeld;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StHeld: begin
                // Index changes while held are ignored; only a release re-arms.
                if (hab_s) begin
                    cnt_d   = '0;
                    state_d = StDebRel;
                end
            end
            StDebRel: begin
                if (!hab_s) begin
                    cnt_d   = '0;
                    state_d = StHeld;
                end else if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
        pressed_d = (state_d == StHeld) || (state_d == StDebRel);
    end

    // Event FIFO
    logic [1:0] mem_q [4];
    logic [1:0] mem_d [4];
    logic [1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0] count_q, count_d;
    logic       overflow_q, overflow_d;
    logic       pop, full, wr_en;

    assign pop   = (count_q != 3'd0) && key_ready;
    assign full  = (count_q == 3'd4);
    // A pop frees the head slot at the same edge, so a push on full still fits.
    assign wr_en = push && (!full || pop);

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = cand_q;
        end
        wr_ptr_d   = wr_en ? wr_ptr_q + 2'd1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 2'd1 : rd_ptr_q;
        count_d    = count_q + {2'b00, wr_en} - {2'b00, pop};
        overflow_d = overflow_q | (push && full && !pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q    <= 3'b100;
            sync2_q    <= 3'b100;
            state_q    <= StIdle;
            cnt_q      <= '0;
            cand_q     <= 2'b00;
            pressed_q  <= 1'b0;
            mem_q      <= '{default: 2'b00};
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            count_q    <= 3'd0;
            overflow_q <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cand_q     <= cand_d;
            pressed_q  <= pressed_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign key_data  = mem_q[rd_ptr_q];
    assign key_valid = (count_q != 3'd0);
    assign key_count = count_q;
    assign pressed   = pressed_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_teclado_controlador.sv
// Bench for teclado_controlador with DEBOUNCE_CYCLES = 4. A run-length model of
// press/release acceptance plus a queue for the FIFO is checked every cycle;
// directed scenarios add literal expectations.
module tb_teclado_controlador;

    localparam int DEB = 4;

    logic       clk;
    logic       rst_n;
    logic [1:0] index_in;
    logic       hab_in;
    logic [1:0] key_data;
    logic       key_valid;
    logic       key_ready;
    logic [2:0] key_count;
    logic       pressed;
    logic       overflow;

    teclado_controlador #(
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .index_in (index_in),
        .hab_in   (hab_in),
        .key_data (key_data),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .key_count(key_count),
        .pressed  (pressed),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // An input is seen by the debouncer two edges after it is sampled. A press
    // is accepted once the same valid key has been seen on DEB+1 consecutive
    // edges; a release once "no key" has been seen on DEB+1 consecutive edges.
    logic [2:0] pipe0, pipe1, seen;
    bit         m_pressed;
    int         run;
    int         cand;
    int         q[$];
    bit         m_ovf;
    bit         m_ok = 1'b0;
    bit         push_ev, pop_ev;

    always @(posedge clk) begin
        if (!rst_n) begin
            pipe0     = 3'b100;
            pipe1     = 3'b100;
            m_pressed = 1'b0;
            run       = 0;
            cand      = 0;
            q.delete();
            m_ovf     = 1'b0;
            m_ok      = 1'b1;
        end else if (m_ok) begin
            seen  = pipe1;
            pipe1 = pipe0;
            pipe0 = hab_in ? 3'b100 : {1'b0, index_in};
            push_ev = 1'b0;
            pop_ev  = (q.size() > 0) && key_ready;
            if (!m_pressed) begin
                if (!seen[2]) begin
                    if (run > 0 && int'(seen[1:0]) == cand) run++;
                    else if (run == 0) begin
                        cand = int'(seen[1:0]);
                        run  = 1;
                    end else run = 0;
                end else run = 0;
                if (run == DEB + 1) begin
                    push_ev   = 1'b1;
                    m_pressed = 1'b1;
                    run       = 0;
                end
            end else begin
                if (seen[2]) run++;
                else run = 0;
                if (run == DEB + 1) begin
                    m_pressed = 1'b0;
                    run       = 0;
                end
            end
            if (pop_ev) void'(q.pop_front());
            if (push_ev) begin
                if (q.size() < 4) q.push_back(cand);
                else m_ovf = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("cyc_valid", int'(key_valid), int'(q.size() > 0));
            chk("cyc_count", int'(key_count), q.size());
            chk("cyc_pressed", int'(pressed), int'(m_pressed));
            chk("cyc_overflow", int'(overflow), int'(m_ovf));
            if (q.size() > 0) chk("cyc_data", int'(key_data), q[0]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic press(input logic [1:0] k);
        hab_in   = 1'b0;
        index_in = k;
    endtask

    task automatic release_key();
        hab_in   = 1'b1;
        index_in = 2'bzx;
    endtask

    task automatic pop_one();
        key_ready = 1'b1;
        step(1);
        key_ready = 1'b0;
    endtask

    int pulses;
    int exp_keys[4] = '{0, 1, 2, 3};

    initial begin
        rst_n     = 1'b0;
        key_ready = 1'b0;
        press(2'b10);

        // 1. reset, then a key held through reset
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("rst_valid", int'(key_valid), 0);
            chk("rst_count", int'(key_count), 0);
            chk("rst_data", int'(key_data), 0);
            chk("rst_pressed", int'(pressed), 0);
            chk("rst_overflow", int'(overflow), 0);
        end
        rst_n = 1'b1;
        step(6);
        chk("t1_valid_early", int'(key_valid), 0);
        step(1);
        chk("t1_valid", int'(key_valid), 1);
        chk("t1_data", int'(key_data), 2);
        chk("t1_count", int'(key_count), 1);
        chk("t1_pressed", int'(pressed), 1);
        pop_one();
        chk("t1_popped", int'(key_count), 0);
        release_key();
        step(8);
        chk("t1_released", int'(pressed), 0);

        // 2. bounce with runs of 2 cycles, then a clean press
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) press(2'b01);
            else release_key();
            step(2);
            chk("t2_no_press", int'(pressed), 0);
            chk("t2_no_event", int'(key_count), 0);
        end
        press(2'b01);
        step(7);
        chk("t2_count", int'(key_count), 1);
        chk("t2_data", int'(key_data), 1);
        pop_one();
        release_key();
        step(8);

        // 3. long hold with ready high: one single-cycle valid pulse
        key_ready = 1'b1;
        press(2'b11);
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (key_valid) begin
                pulses++;
                chk("t3_data", int'(key_data), 3);
            end
            if (i >= 6) chk("t3_pressed", int'(pressed), 1);
        end
        chk("t3_pulses", pulses, 1);
        release_key();
        step(8);
        key_ready = 1'b0;

        // 4. index change while held is ignored
        press(2'b00);
        step(8);
        chk("t4_first", int'(key_count), 1);
        press(2'b01);
        step(10);
        chk("t4_ignored", int'(key_count), 1);
        chk("t4_still_held", int'(pressed), 1);
        release_key();
        step(8);
        chk("t4_release", int'(pressed), 0);
        chk("t4_no_new", int'(key_count), 1);
        press(2'b01);
        step(7);
        chk("t4_second", int'(key_count), 2);
        key_ready = 1'b1;
        step(2);
        key_ready = 1'b0;
        chk("t4_drained", int'(key_count), 0);
        release_key();
        step(8);

        // 5. overflow: five presses, ready low
        for (int i = 0; i < 5; i++) begin
            press(2'(i % 4));
            step(7);
            release_key();
            step(7);
        end
        chk("t5_count", int'(key_count), 4);
        chk("t5_overflow", int'(overflow), 1);
        for (int i = 0; i < 4; i++) begin
            chk("t5_pop_data", int'(key_data), exp_keys[i]);
            pop_one();
        end
        chk("t5_empty", int'(key_count), 0);
        chk("t5_ovf_sticky", int'(overflow), 1);

        // 6. full FIFO with simultaneous push/pop, then reset mid-press
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        chk("t6_ovf_cleared", int'(overflow), 0);
        for (int i = 0; i < 4; i++) begin
            press(2'(i));
            step(7);
            release_key();
            step(7);
        end
        chk("t6_full", int'(key_count), 4);
        press(2'b10);
        step(6);
        key_ready = 1'b1;
        step(1);
        key_ready = 1'b0;
        chk("t6_count_kept", int'(key_count), 4);
        chk("t6_no_overflow", int'(overflow), 0);
        chk("t6_head", int'(key_data), 1);
        release_key();
        step(8);
        press(2'b01);
        step(4);
        rst_n = 1'b0;
        release_key();
        step(1);
        chk("t6_rst_empty", int'(key_count), 0);
        rst_n = 1'b1;
        step(12);
        chk("t6_no_event", int'(key_count), 0);
        chk("t6_not_pressed", int'(pressed), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
